// File: rtl/uart_rx_if.sv
// Receiver-side bus for uart_rx: line input, rate select, received byte with status, and FSM debug state.
`timescale 1ns/1ps
interface uart_rx_if;
  // rx_done is a strobe with no back-pressure. It is high for exactly one mclk
  // cycle, and data_byte, frame_err and parity_err are valid in that cycle.
  // These outputs then hold until the next completed frame.
  logic [3:0] baud_set;
  logic       rs232_rx;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;
  logic [2:0] rx_state;

  modport master (
    input  baud_set, rs232_rx,
    output data_byte, rx_done, frame_err, parity_err, rx_busy, rx_state
  );
  modport slave (
    output baud_set, rs232_rx,
    input  data_byte, rx_done, frame_err, parity_err, rx_busy, rx_state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_rx #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     mclk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0] SUB_S0   = 4'(OSR / 2 - 1);
  localparam logic [3:0] SUB_S1   = 4'(OSR / 2);
  localparam logic [3:0] SUB_S2   = 4'(OSR / 2 + 1);
  localparam logic [3:0] SUB_LAST = 4'(OSR - 1);
  localparam int         FW       = $clog2(SYNC_STAGES + 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, armed;
  logic [FW-1:0]          flush_cnt;
  logic [8:0]             tdiv_q, div_cnt;
  logic [3:0]             sub_cnt;
  logic [2:0]             bit_cnt;
  logic                   s0, s1, maj, tick, fall;
  logic                   start_det, stop_dec;
  logic [7:0]             shift_q, data_q;
  logic                   done_q, ferr_q, perr_q;

  function automatic logic [8:0] tdiv_of(input logic [3:0] b);
    case (b)
      4'd0:    tdiv_of = 9'd1;
      4'd1:    tdiv_of = 9'd162;
      4'd2:    tdiv_of = 9'd80;
      4'd3:    tdiv_of = 9'd53;
      default: tdiv_of = 9'd325;
    endcase
  endfunction

  assign rx_s = sync_q[SYNC_STAGES-1];
  // armed blocks a line that is already low when reset releases from looking like a start edge.
  assign fall = armed & rx_prev & ~rx_s;
  assign tick = (state != S_IDLE) && (div_cnt == tdiv_q);
  assign maj  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev   <= 1'b1;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.rs232_rx};
      rx_prev <= rx_s;
      if (flush_cnt != FW'(SYNC_STAGES)) flush_cnt <= flush_cnt + 1'b1;
      else if (rx_s)                     armed     <= 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    stop_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nxt = S_START;
          start_det = 1'b1;
        end
      end
      S_START: begin
        if (tick && sub_cnt == SUB_S2 && maj)  state_nxt = S_IDLE;
        else if (tick && sub_cnt == SUB_LAST)  state_nxt = S_DATA;
      end
      S_DATA: begin
        if (tick && sub_cnt == SUB_LAST && bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
      end
      S_PARITY: begin
        if (tick && sub_cnt == SUB_LAST) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (tick && sub_cnt == SUB_S2) begin
          state_nxt = S_IDLE;
          stop_dec  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      tdiv_q  <= '0;
      div_cnt <= '0;
      sub_cnt <= '0;
      bit_cnt <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      done_q <= stop_dec;
      if (start_det) begin
        tdiv_q  <= tdiv_of(bus.baud_set);
        div_cnt <= '0;
        sub_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == S_IDLE) begin
        div_cnt <= '0;
        sub_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        sub_cnt <= sub_cnt + 1'b1;
        if (sub_cnt == SUB_S0) s0 <= rx_s;
        if (sub_cnt == SUB_S1) s1 <= rx_s;
        if (state == S_DATA && sub_cnt == SUB_S2)   shift_q <= {maj, shift_q[7:1]};
        if (state == S_DATA && sub_cnt == SUB_LAST) bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (state == S_PARITY && sub_cnt == SUB_S2) perr_q <= maj ^ (^shift_q);
`endif
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (stop_dec) begin
        data_q <= shift_q;
        ferr_q <= ~maj;
      end
    end
  end

  // Parity is judged at its own bit but published together with the stop decision.
  logic perr_out_q;
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)        perr_out_q <= 1'b0;
    else if (stop_dec) perr_out_q <= perr_q;
  end

  assign bus.data_byte  = data_q;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_out_q;
  assign bus.rx_busy    = (state != S_IDLE);
  assign bus.rx_state   = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit-by-bit, rx_done results checked against an expected queue.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic mclk;
  logic rst_n;
  uart_rx_if u_if ();

  uart_rx dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;
  logic        prev_done = 1'b0;
  logic [9:0]  exp_q[$];

  // clock / reset
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, required finish before 1500000 ns");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic fe, input logic pe, input logic [7:0] d);
    exp_q.push_back({fe, pe, d});
  endtask

  // Drives one frame starting at a negedge; glitch_c pulls the line low for two cycles, max_c truncates the frame.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int cpb, input int glitch_c, input int max_c);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, d, 1'b0};
`else
    bits = {1'b1, stop, d, 1'b0};
`endif
    for (int c = 0; c < NBITS * cpb && c < max_c; c++) begin
      u_if.rs232_rx = bits[c / cpb];
      if (c == glitch_c || c == glitch_c + 1) u_if.rs232_rx = 1'b0;
      @(negedge mclk);
    end
    u_if.rs232_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // scoreboard
  always @(negedge mclk) begin
    logic [9:0] e;
    if (u_if.rx_done) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("frame", {22'd0, u_if.frame_err, u_if.parity_err, u_if.data_byte}, {22'd0, e});
      end
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    prev_done = u_if.rx_done;
  end

  initial begin
    int t0;
    int base;
    u_if.rs232_rx = 1'b1;
    u_if.baud_set = 4'd0;
    rst_n = 1'b0;
    idle(4);
    chk("rst_data", {24'd0, u_if.data_byte}, 32'h00);
    chk("rst_done", {31'd0, u_if.rx_done}, 32'd0);
    chk("rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    chk("rst_perr", {31'd0, u_if.parity_err}, 32'd0);
    chk("rst_busy", {31'd0, u_if.rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // clean 0xA5, latency from start edge about 9.5 bits
    push_exp(1'b0, 1'b0, 8'hA5);
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 32, -10, 1 << 20);
      begin
        idle(100);
        chk("t1_busy_mid", {31'd0, u_if.rx_busy}, 32'd1);
      end
    join
    idle(30);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_latency_ok", {31'd0, (last_done_cyc - t0) >= 300 && (last_done_cyc - t0) <= 320}, 32'd1);
    chk("t1_busy_after", {31'd0, u_if.rx_busy}, 32'd0);

    // 6-cycle low blip is a false start
    u_if.rs232_rx = 1'b0;
    idle(6);
    u_if.rs232_rx = 1'b1;
    idle(4);
    chk("t2_busy_start", {31'd0, u_if.rx_busy}, 32'd1);
    idle(30);
    chk("t2_busy_drop", {31'd0, u_if.rx_busy}, 32'd0);
    idle(400);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_data_hold", {24'd0, u_if.data_byte}, 32'hA5);

    // framing error, then a clean frame clears it
    push_exp(1'b1, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 32, -10, 1 << 20);
    idle(40);
    chk("t3_ferr_hold", {31'd0, u_if.frame_err}, 32'd1);
    chk("t3_data_on_ferr", {24'd0, u_if.data_byte}, 32'h3C);
    push_exp(1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, 32, -10, 1 << 20);
    idle(40);
    chk("t3_ferr_clear", {31'd0, u_if.frame_err}, 32'd0);
    chk("t3_done_cnt", done_cnt, 3);

    // spike at mid of data bit 3 (frame bit 4, cycles 143..144) is outvoted
    push_exp(1'b0, 1'b0, 8'hFF);
    send_frame(8'hFF, 1'b0, 1'b1, 32, 143, 1 << 20);
    idle(40);
    chk("t4_data", {24'd0, u_if.data_byte}, 32'hFF);

    // 19200: back-to-back 0x00, 0xFF with no idle gap
    u_if.baud_set = 4'd1;
    idle(4);
    push_exp(1'b0, 1'b0, 8'h00);
    push_exp(1'b0, 1'b0, 8'hFF);
    send_frame(8'h00, 1'b0, 1'b1, 2608, -10, 1 << 20);
    send_frame(8'hFF, 1'b0, 1'b1, 2608, -10, 1 << 20);
    idle(200);
    chk("t5_done_cnt", done_cnt, 6);
    chk("t5_gap_ok", {31'd0, (last_done_cyc - prev_done_cyc) >= 26070 &&
                            (last_done_cyc - prev_done_cyc) <= 26090}, 32'd1);

    // reset in the middle of data bit 4 of 0x55
    send_frame(8'h55, 1'b0, 1'b1, 2608, -10, 5 * 2608 + 1304);
    chk("t5_busy_pre_rst", {31'd0, u_if.rx_busy}, 32'd1);
    rst_n = 1'b0;
    idle(2);
    chk("t5_rst_data", {24'd0, u_if.data_byte}, 32'h00);
    chk("t5_rst_busy", {31'd0, u_if.rx_busy}, 32'd0);
    chk("t5_rst_ferr", {31'd0, u_if.frame_err}, 32'd0);
    chk("t5_rst_done", {31'd0, u_if.rx_done}, 32'd0);
    rst_n = 1'b1;
    idle(200);
    chk("t5_no_done", done_cnt, 6);

    // a line held low through reset release is not a start
    u_if.baud_set = 4'd0;
    rst_n = 1'b0;
    u_if.rs232_rx = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(30);
    chk("t6_low_release_busy", {31'd0, u_if.rx_busy}, 32'd0);
    idle(370);
    u_if.rs232_rx = 1'b1;
    idle(20);
    chk("t6_low_release_done", done_cnt, 6);

    push_exp(1'b0, 1'b0, 8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 32, -10, 1 << 20);
    idle(40);
    chk("t6_done_cnt", done_cnt, 7);
    chk("t6_data", {24'd0, u_if.data_byte}, 32'h55);

`ifdef UART_RX_PARITY_EN
    push_exp(1'b0, 1'b1, 8'h01);
    send_frame(8'h01, 1'b0, 1'b1, 32, -10, 1 << 20);
    idle(40);
    chk("t7_perr_bad", {31'd0, u_if.parity_err}, 32'd1);
    push_exp(1'b0, 1'b0, 8'h01);
    send_frame(8'h01, 1'b1, 1'b1, 32, -10, 1 << 20);
    idle(40);
    chk("t7_perr_good", {31'd0, u_if.parity_err}, 32'd0);
    chk("t7_done_cnt", done_cnt, 9);
`else
    push_exp(1'b0, 1'b0, 8'h01);
    send_frame(8'h01, 1'b0, 1'b1, 32, -10, 1 << 20);
    idle(40);
    chk("t7_perr_tied", {31'd0, u_if.parity_err}, 32'd0);
    chk("t7_done_cnt", done_cnt, 8);
`endif

    chk("exp_left", exp_q.size(), 0);
    base = n_checks;
    $display("Result: errors=%0d of %0d checks", n_errors, base);
    $finish;
  end

endmodule
